// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: op-code and FSM state encodings shared by shift_seq8 and shift_step1
package shift_seq_pkg;

    typedef enum logic [2:0] {
        LSR  = 3'b000,
        LSL  = 3'b001,
        ASR  = 3'b010,
        LSL2 = 3'b011,
        ROR  = 3'b100,
        ROL  = 3'b101
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // 110 and 111 are the only unassigned codes
    localparam logic [2:0] OP_ILL_MASK = 3'b110;

    function automatic logic op_illegal(input logic [2:0] op);
        return (op & OP_ILL_MASK) == OP_ILL_MASK;
    endfunction

endpackage

// File: rtl/shift_step1.sv
// shift_step1: combinational single-bit step of a shift/rotate op; illegal codes yield 0
module shift_step1
    import shift_seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] res
);

    always_comb begin
        res = (op == LSR)                ? {1'b0, data[DATA_W-1:1]}
            : (op == LSL || op == LSL2)  ? {data[DATA_W-2:0], 1'b0}
            : (op == ASR)                ? {data[DATA_W-1], data[DATA_W-1:1]}
            : (op == ROR)                ? {data[0], data[DATA_W-1:1]}
            : (op == ROL)                ? {data[DATA_W-2:0], data[DATA_W-1]}
            :                              '0;
    end

endmodule

// File: rtl/shift_seq8.sv
// shift_seq8: multi-cycle variable-amount shifter, one bit per clock, valid/ready on both sides.
// Define SHIFT_SEQ_ERR_EN to add the op_err output flagging illegal op codes.
module shift_seq8
    import shift_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int AMT_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        shift_type,
    input  logic [AMT_W-1:0]  shift_amt,
    input  logic [DATA_W-1:0] din,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] dout,
    output logic              busy
`ifdef SHIFT_SEQ_ERR_EN
    ,
    output logic              op_err
`endif
);

    state_e            state, state_nx;
    logic [2:0]        op_q;
    logic [AMT_W-1:0]  cnt;
    logic [DATA_W-1:0] data_q, step_res;
    logic              accept;

    shift_step1 #(.DATA_W(DATA_W)) u_step (
        .op   (op_q),
        .data (data_q),
        .res  (step_res)
    );

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        accept    = in_valid && in_ready;
        if (accept)
            state_nx = (shift_amt == '0 || op_illegal(shift_type)) ? DONE : SHIFT;
        else if (state == SHIFT && cnt == AMT_W'(1))
            state_nx = DONE;
        else if (state == DONE && out_ready)
            state_nx = IDLE;
    end

    // data_q doubles as the result register: it only moves in SHIFT, so it is stable in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            cnt    <= '0;
            data_q <= '0;
        end else if (accept) begin
            op_q   <= shift_type;
            cnt    <= shift_amt;
            data_q <= op_illegal(shift_type) ? '0 : din;
        end else if (state == SHIFT) begin
            cnt    <= cnt - 1'b1;
            data_q <= step_res;
        end
    end

    assign dout = data_q;

`ifdef SHIFT_SEQ_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (accept)
            err_q <= op_illegal(shift_type);
    end

    assign op_err = err_q && out_valid;
`endif

endmodule

// File: tb/tb_shift_seq8.sv
// tb_shift_seq8: directed and random checks of shift_seq8 against hand values and a reference model
module tb_shift_seq8;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] shift_type;
    logic [2:0] shift_amt;
    logic [7:0] din;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] dout;
    logic       busy;
`ifdef SHIFT_SEQ_ERR_EN
    logic       op_err;
`endif

    int total = 0;
    int bad   = 0;

    shift_seq8 dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .shift_type (shift_type),
        .shift_amt  (shift_amt),
        .din        (din),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dout       (dout),
        .busy       (busy)
`ifdef SHIFT_SEQ_ERR_EN
        ,
        .op_err     (op_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // whole-word reference: shifts by the full amount at once rather than stepping
    function automatic logic [7:0] model(input logic [2:0] op, input logic [2:0] amt, input logic [7:0] d);
        logic [15:0] dd;
        dd = {d, d};
        case (op)
            3'b000:         return d >> amt;
            3'b001, 3'b011: return d << amt;
            3'b010:         return 8'($signed(d) >>> amt);
            3'b100:         return 8'(dd >> amt);
            3'b101:         return 8'((dd << amt) >> 8);
            default:        return 8'h00;
        endcase
    endfunction

    // called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
    task automatic run(input string tag, input logic [2:0] op, input logic [2:0] amt,
                       input logic [7:0] d, input logic [7:0] exp, input int bp);
        int n;
        int lat;
        lat = (amt == 3'd0 || op[2:1] == 2'b11) ? 1 : int'(amt) + 1;
        in_valid = 1'b1; shift_type = op; shift_amt = amt; din = d;
        @(negedge clk);
        in_valid = 1'b0; din = ~d;
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_dout"}, dout, exp);
`ifdef SHIFT_SEQ_ERR_EN
        chk({tag, "_err"}, op_err, op[2:1] == 2'b11);
`endif
        for (int i = 0; i < bp; i++) @(negedge clk);
        chk({tag, "_hold"}, {out_valid, dout}, {1'b1, exp});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_rel"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        logic [2:0] op, amt;
        logic [7:0] d;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        shift_type = '0; shift_amt = '0; din = '0;
        repeat (2) @(negedge clk);
        chk("rst", {in_ready, out_valid, busy, dout}, {3'b100, 8'h00});
        rst = 1'b0;
        @(negedge clk);

        run("ror3",  3'b100, 3'd3, 8'b1011_0001, 8'b0011_0110, 0);
        run("asr2",  3'b010, 3'd2, 8'h90, 8'hE4, 0);
        run("lsr2",  3'b000, 3'd2, 8'h90, 8'h24, 0);
        run("lsl7",  3'b001, 3'd7, 8'h03, 8'h80, 0);
        run("rol0",  3'b101, 3'd0, 8'h5A, 8'h5A, 0);
        run("ill7",  3'b111, 3'd4, 8'hFF, 8'h00, 0);
        run("ill6",  3'b110, 3'd5, 8'hA5, 8'h00, 0);
        run("lsl2c", 3'b011, 3'd1, 8'h81, 8'h02, 0);
        run("rol3",  3'b101, 3'd3, 8'h81, 8'h0C, 0);
        run("asr7",  3'b010, 3'd7, 8'h80, 8'hFF, 0);
        run("asrp",  3'b010, 3'd3, 8'h70, 8'h0E, 0);
        run("ror7",  3'b100, 3'd7, 8'h01, 8'h02, 0);
        run("lsr7",  3'b000, 3'd7, 8'hFF, 8'h01, 0);

        // backpressure: result held, new requests ignored while DONE
        in_valid = 1'b1; shift_type = 3'b001; shift_amt = 3'd2; din = 8'h05;
        @(negedge clk);
        chk("bp_busy", {busy, in_ready}, 2'b10);
        shift_type = 3'b000; shift_amt = 3'd1; din = 8'hF0;
        repeat (2) @(negedge clk);
        chk("bp_valid", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_stall", {out_valid, in_ready, dout}, {2'b10, 8'h14});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_rel", {out_valid, in_ready, dout}, {2'b01, 8'h14});

        // reset in the middle of a long shift aborts it
        in_valid = 1'b1; shift_type = 3'b100; shift_amt = 3'd7; din = 8'hA5;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst", {in_ready, out_valid, busy, dout}, {3'b100, 8'h00});
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_quiet", {in_ready, out_valid, busy}, 3'b100);

        for (int k = 0; k < 1000; k++) begin
            op  = 3'($urandom_range(0, 7));
            amt = 3'($urandom_range(0, 7));
            d   = 8'($urandom);
            run("rnd", op, amt, d, model(op, amt, d), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
